alien_formation: RTL and testbench
==================================

# alien_formation

Renders and moves the grid of invaders as one drawable object. It consumes the pixel coordinates and frame strobe produced by the video unit, and produces one `draw_request`/RGB pair that feeds one slot of the video unit's object inputs. It keeps the alive mask, steps the formation sideways every few frames, drops it one row at each screen edge, and reports kill count and end-of-wave conditions to game logic.

## Interface
Parameters:
- `ROWS`, 3: formation rows (1..8).
- `COLS`, 8: formation columns (1..16).
- `CELL_W`, 32: cell pitch in X, in pixels. Must be a power of two.
- `CELL_H`, 32: cell pitch in Y, in pixels. Must be a power of two.
- `SPRITE_W`, 24: drawn width inside a cell, in pixels. Must be ≤ `CELL_W`.
- `SPRITE_H`, 16: drawn height inside a cell, in pixels. Must be ≤ `CELL_H`.
- `PIXEL_WIDTH`, 11: coordinate width.
- `RGB_WIDTH`, 8: colour width.
- `START_X`, 64: formation top-left X at reset.
- `START_Y`, 48: formation top-left Y at reset.
- `SCREEN_W`, 640: right bound, exclusive.
- `BOTTOM_Y`, 400: Y at which the wave has landed.
- `STEP_X`, 4: horizontal step, in pixels.
- `STEP_Y`, 16: drop distance at an edge, in pixels.
- `MOVE_PERIOD`, 8: frames per move (≥1).
- `COLOR_A`, 8'h1C: colour for animation phase 0.
- `COLOR_B`, 8'hFC: colour for animation phase 1.

Ports:
- `clk`, in, 1: system clock (pixel clock domain).
- `resetN`, in, 1: asynchronous, active-low reset.
- `pixelX`, in, `PIXEL_WIDTH`: current scan X.
- `pixelY`, in, `PIXEL_WIDTH`: current scan Y.
- `startOfFrame`, in, 1: frame strobe. Only its rising edge is used.
- `enable`, in, 1: movement enable. When 0 the formation freezes; drawing and hits stay active.
- `hit_valid`, in, 1: one-cycle kill request.
- `hit_row`, in, 3: row to kill.
- `hit_col`, in, 4: column to kill.
- `draw_request`, out, 1: current pixel belongs to a live alien.
- `RGBout`, out, `RGB_WIDTH`: colour of that pixel.
- `alive_count`, out, 8: number of live aliens.
- `all_dead`, out, 1: `alive_count` == 0.
- `reached_bottom`, out, 1: `topY + ROWS*CELL_H` ≥ `BOTTOM_Y`.

## Operation
- State registers:
  - `topX` and `topY` (`PIXEL_WIDTH` bits each).
  - `dir`: 0 = right, 1 = left.
  - `anim`: 1-bit animation phase.
  - `frame_cnt`: counts 0..`MOVE_PERIOD`-1.
  - `alive`: `ROWS*COLS`-bit mask.
  - `sof_d`: delayed `startOfFrame`, used for edge detection.
- Reset values:
  - `topX`=`START_X`, `topY`=`START_Y`, `dir`=0, `anim`=0, `frame_cnt`=0.
  - `alive` all ones; `alive_count`=`ROWS*COLS`.
  - `draw_request`=0, `RGBout`=0.
  - `all_dead`=0 and `reached_bottom`=0, given a legal parameter set.
- Frame tick: `sof_rise` = `startOfFrame` & ~`sof_d`. A tick is counted only when `enable`=1.
  - On a tick with `frame_cnt`=`MOVE_PERIOD`-1: `frame_cnt`←0 and a move happens.
  - Otherwise a tick increments `frame_cnt`.
- The move is a two-state decision on `dir`:
  - RIGHT: if `topX + COLS*CELL_W + STEP_X` > `SCREEN_W`, then `topY` += `STEP_Y`, `dir`←LEFT, and X is unchanged. Otherwise `topX` += `STEP_X`.
  - LEFT: if `topX` < `STEP_X`, then `topY` += `STEP_Y`, `dir`←RIGHT, and X is unchanged. Otherwise `topX` -= `STEP_X`.
  - Every move toggles `anim`.
- Bounds use the full grid width, including dead columns.
- Once `reached_bottom`=1, moves stop: no further X or Y change and no `anim` toggle. `frame_cnt` keeps counting.
- Hit handling:
  - A hit with `hit_valid`=1, `hit_row`<`ROWS`, `hit_col`<`COLS` and that alien alive clears its bit and decrements `alive_count` on the same edge.
  - An out-of-range hit or a hit on a dead alien changes nothing.
- Simultaneous hit and move on the same edge: both apply independently.
- Draw path:
  - `relX` = `pixelX - topX`, `relY` = `pixelY - topY`, computed with one extra bit to detect negative values.
  - Inside = `relX` and `relY` non-negative, `relX` < `COLS*CELL_W`, and `relY` < `ROWS*CELL_H`.
  - `col` = `relX >> log2(CELL_W)`, `row` = `relY >> log2(CELL_H)`.
  - Within-cell offsets are the low bits of `relX`/`relY`; the pixel is in the sprite when they are < `SPRITE_W`/`SPRITE_H`.
  - Hit = inside & in-sprite & `alive[row][col]`.
  - `RGBout` = `anim` ? `COLOR_B` : `COLOR_A` when hit, else 0.
- Reset asserted mid-frame or mid-move: all state returns to reset values immediately. No partial move survives.

## Timing
- `draw_request`/`RGBout` are registered: 1-cycle latency from `pixelX`/`pixelY`.
- Position changes take effect on the clock edge after the detected rising edge of `startOfFrame` (the edge on which `sof_d` is still 0).
- `alive_count` and `all_dead` update on the edge that samples a valid `hit_valid`.
- `reached_bottom` is combinational from registered `topY`.
- A hit lands within the current frame. A partially drawn sprite disappears starting with the next pixel cycle after the update.

## Test plan
- Reset with `pixelX`=`START_X`, `pixelY`=`START_Y` -> 1 cycle later `draw_request`=1, `RGBout`=8'h1C, `alive_count`=24; at `pixelX`=`START_X`+24 -> `draw_request`=0 (gap between sprites).
- `enable`=1, 8 `startOfFrame` pulses -> `topX`=68, `anim`=1, colour 8'hFC; 7 pulses -> `topX` unchanged at 64.
- Drive moves until the right edge: the move where `topX`+256+4 > 640 leaves `topX` unchanged, adds 16 to `topY`, sets `dir`=LEFT; the next move gives `topX` -= 4.
- `hit_valid` at row 1, col 2 -> `alive_count`=23 and that cell is not drawn. Repeat the same hit -> still 23. Hit row 5 -> ignored. Hit coincident with a move -> both applied.
- Kill all 24 -> `all_dead`=1 and `draw_request` never asserts. Move down until `topY`+96 ≥ 400 -> `reached_bottom`=1 and position frozen.
- Assert `resetN`=0 mid-frame after several moves and hits -> `topX`=64, `topY`=48, `alive_count`=24, outputs 0 asynchronously.

Source files
------------

// File: rtl/alien_formation.sv
// alien_formation: invader grid as one drawable object.
// Keeps the alive mask, steps the formation sideways every MOVE_PERIOD frames,
// drops it one row at each screen edge, and reports kills / end-of-wave status.
// Ports:
//   clk, resetN           clock, asynchronous active-low reset
//   pixelX, pixelY        current scan coordinates from the video unit
//   startOfFrame          frame strobe (rising edge used)
//   enable                movement enable (drawing and hits stay active)
//   hit_valid/row/col     one-cycle kill request
//   draw_request, RGBout  registered draw output for one video object slot
//   alive_count, all_dead live alien count and wave-cleared flag
//   reached_bottom        formation has landed (combinational from topY)
module alien_formation #(
    parameter int unsigned ROWS        = 3,
    parameter int unsigned COLS        = 8,
    parameter int unsigned CELL_W      = 32,
    parameter int unsigned CELL_H      = 32,
    parameter int unsigned SPRITE_W    = 24,
    parameter int unsigned SPRITE_H    = 16,
    parameter int unsigned PIXEL_WIDTH = 11,
    parameter int unsigned RGB_WIDTH   = 8,
    parameter int unsigned START_X     = 64,
    parameter int unsigned START_Y     = 48,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned BOTTOM_Y    = 400,
    parameter int unsigned STEP_X      = 4,
    parameter int unsigned STEP_Y      = 16,
    parameter int unsigned MOVE_PERIOD = 8,
    parameter logic [RGB_WIDTH-1:0] COLOR_A = RGB_WIDTH'(8'h1C),
    parameter logic [RGB_WIDTH-1:0] COLOR_B = RGB_WIDTH'(8'hFC)
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [PIXEL_WIDTH-1:0] pixelX,
    input  logic [PIXEL_WIDTH-1:0] pixelY,
    input  logic                   startOfFrame,
    input  logic                   enable,
    input  logic                   hit_valid,
    input  logic [2:0]             hit_row,
    input  logic [3:0]             hit_col,
    output logic                   draw_request,
    output logic [RGB_WIDTH-1:0]   RGBout,
    output logic [7:0]             alive_count,
    output logic                   all_dead,
    output logic                   reached_bottom
);

    localparam int unsigned PW     = PIXEL_WIDTH;
    localparam int unsigned RW     = PIXEL_WIDTH + 1;   // signed-detect width for relative coords
    localparam int unsigned XW     = PIXEL_WIDTH + 2;   // headroom for bound sums
    localparam int unsigned GRID_W = COLS * CELL_W;
    localparam int unsigned GRID_H = ROWS * CELL_H;
    localparam int unsigned CW_LOG = $clog2(CELL_W);
    localparam int unsigned CH_LOG = $clog2(CELL_H);
    localparam int unsigned RI     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CI     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned FW     = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;

    typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_t;

    dir_t                      dir_q, dir_d;
    logic [PW-1:0]             top_x, top_x_d;
    logic [PW-1:0]             top_y, top_y_d;
    logic                      anim, anim_d;
    logic [FW-1:0]             frame_cnt;
    logic [ROWS-1:0][COLS-1:0] alive;
    logic                      sof_d;

    // Frame tick and move decision
    logic tick_c, wrap_c, move_c, right_edge_c, left_edge_c;
    assign tick_c       = startOfFrame & ~sof_d & enable;
    assign wrap_c       = (frame_cnt == FW'(MOVE_PERIOD - 1));
    assign move_c       = tick_c & wrap_c & ~reached_bottom;
    assign right_edge_c = (XW'(top_x) + XW'(GRID_W + STEP_X)) > XW'(SCREEN_W);
    assign left_edge_c  = top_x < PW'(STEP_X);

    assign reached_bottom = (XW'(top_y) + XW'(GRID_H)) >= XW'(BOTTOM_Y);
    assign all_dead       = (alive_count == 8'd0);

    // Hit qualification: in range and currently alive
    logic hit_ok_c;
    assign hit_ok_c = hit_valid
                    & (8'(hit_row) < 8'(ROWS))
                    & (8'(hit_col) < 8'(COLS))
                    & alive[hit_row[RI-1:0]][hit_col[CI-1:0]];

    // Draw path: position relative to the formation origin
    logic [RW-1:0] rel_x_c, rel_y_c, off_x_c, off_y_c;
    logic          inside_c, sprite_c, pix_hit_c;
    assign rel_x_c   = {1'b0, pixelX} - {1'b0, top_x};
    assign rel_y_c   = {1'b0, pixelY} - {1'b0, top_y};
    assign inside_c  = ~rel_x_c[RW-1] & ~rel_y_c[RW-1]
                     & (rel_x_c < RW'(GRID_W)) & (rel_y_c < RW'(GRID_H));
    assign off_x_c   = rel_x_c & RW'(CELL_W - 1);
    assign off_y_c   = rel_y_c & RW'(CELL_H - 1);
    assign sprite_c  = (off_x_c < RW'(SPRITE_W)) & (off_y_c < RW'(SPRITE_H));
    assign pix_hit_c = inside_c & sprite_c
                     & alive[rel_y_c[CH_LOG +: RI]][rel_x_c[CW_LOG +: CI]];

    // Movement FSM: state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dir_q <= DIR_RIGHT;
            top_x <= PW'(START_X);
            top_y <= PW'(START_Y);
            anim  <= 1'b0;
        end else begin
            dir_q <= dir_d;
            top_x <= top_x_d;
            top_y <= top_y_d;
            anim  <= anim_d;
        end
    end

    // Movement FSM: next state; an edge move drops and reverses without X change
    always_comb begin
        dir_d   = dir_q;
        top_x_d = top_x;
        top_y_d = top_y;
        anim_d  = anim;
        if (move_c) begin
            anim_d = ~anim;
            case (dir_q)
                DIR_RIGHT: begin
                    if (right_edge_c) begin
                        top_y_d = top_y + PW'(STEP_Y);
                        dir_d   = DIR_LEFT;
                    end else begin
                        top_x_d = top_x + PW'(STEP_X);
                    end
                end
                DIR_LEFT: begin
                    if (left_edge_c) begin
                        top_y_d = top_y + PW'(STEP_Y);
                        dir_d   = DIR_RIGHT;
                    end else begin
                        top_x_d = top_x - PW'(STEP_X);
                    end
                end
                default: dir_d = DIR_RIGHT;
            endcase
        end
    end

    // Frame counter, alive mask and registered draw outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sof_d        <= 1'b0;
            frame_cnt    <= '0;
            alive        <= '1;
            alive_count  <= 8'(ROWS * COLS);
            draw_request <= 1'b0;
            RGBout       <= '0;
        end else begin
            sof_d <= startOfFrame;
            if (tick_c) begin
                frame_cnt <= wrap_c ? '0 : frame_cnt + FW'(1);
            end
            if (hit_ok_c) begin
                alive[hit_row[RI-1:0]][hit_col[CI-1:0]] <= 1'b0;
                alive_count <= alive_count - 8'd1;
            end
            draw_request <= pix_hit_c;
            RGBout       <= pix_hit_c ? (anim ? COLOR_B : COLOR_A) : '0;
        end
    end

endmodule

// File: tb/tb_alien_formation.sv
// Self-checking bench for alien_formation: directed table, hand-written
// movement/hit sequences, and randomized traffic against a behavioural model.
module tb_alien_formation;

    localparam int ROWS = 3, COLS = 8, CELL_W = 32, CELL_H = 32;
    localparam int SPRITE_W = 24, SPRITE_H = 16;
    localparam int START_X = 64, START_Y = 48, SCREEN_W = 640, BOTTOM_Y = 400;
    localparam int STEP_X = 4, STEP_Y = 16, MOVE_PERIOD = 8;
    localparam int COLOR_A = 'h1C, COLOR_B = 'hFC;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, enable, hit_valid;
    logic [2:0]  hit_row;
    logic [3:0]  hit_col;
    logic        draw_request;
    logic [7:0]  RGBout;
    logic [7:0]  alive_count;
    logic        all_dead, reached_bottom;

    always #5 clk = ~clk;

    alien_formation dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .enable(enable), .hit_valid(hit_valid),
        .hit_row(hit_row), .hit_col(hit_col), .draw_request(draw_request),
        .RGBout(RGBout), .alive_count(alive_count), .all_dead(all_dead),
        .reached_bottom(reached_bottom)
    );

    // Behavioural reference state
    int m_topx, m_topy, m_dir, m_anim, m_fc, m_count;
    bit m_sofd;
    bit m_alive [ROWS][COLS];

    int vectors = 0;
    int miscompares = 0;

    function automatic void model_reset();
        m_topx = START_X; m_topy = START_Y; m_dir = 0; m_anim = 0; m_fc = 0;
        m_sofd = 0; m_count = ROWS * COLS;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_alive[r][c] = 1;
    endfunction

    function automatic bit model_bottom();
        return (m_topy + ROWS * CELL_H) >= BOTTOM_Y;
    endfunction

    function automatic bit model_pix(int px, int py);
        int rx, ry;
        rx = px - m_topx;
        ry = py - m_topy;
        if (rx < 0 || ry < 0 || rx >= COLS * CELL_W || ry >= ROWS * CELL_H) return 0;
        if ((rx % CELL_W) >= SPRITE_W || (ry % CELL_H) >= SPRITE_H) return 0;
        return m_alive[ry / CELL_H][rx / CELL_W];
    endfunction

    function automatic void model_step(bit sof, bit en, bit hv, int hr, int hc);
        bit rise;
        rise = sof && !m_sofd;
        m_sofd = sof;
        if (rise && en) begin
            if (m_fc == MOVE_PERIOD - 1) begin
                m_fc = 0;
                if (!model_bottom()) begin
                    m_anim = 1 - m_anim;
                    if (m_dir == 0) begin
                        if (m_topx + COLS * CELL_W + STEP_X > SCREEN_W) begin
                            m_topy += STEP_Y; m_dir = 1;
                        end else m_topx += STEP_X;
                    end else begin
                        if (m_topx < STEP_X) begin
                            m_topy += STEP_Y; m_dir = 0;
                        end else m_topx -= STEP_X;
                    end
                end
            end else m_fc++;
        end
        if (hv && hr < ROWS && hc < COLS && m_alive[hr][hc]) begin
            m_alive[hr][hc] = 0;
            m_count--;
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, compare #1 later
    task automatic apply(input bit sof, input bit en, input bit hv, input int hr,
                         input int hc, input int px, input int py);
        bit e_draw;
        int e_rgb;
        startOfFrame = sof; enable = en; hit_valid = hv;
        hit_row = 3'(hr); hit_col = 4'(hc);
        pixelX = 11'(px); pixelY = 11'(py);
        e_draw = model_pix(px, py);
        e_rgb  = e_draw ? (m_anim ? COLOR_B : COLOR_A) : 0;
        @(posedge clk);
        model_step(sof, en, hv, hr, hc);
        #1;
        vectors++;
        check("draw_request", int'(draw_request), int'(e_draw));
        check("RGBout", int'(RGBout), e_rgb);
        check("alive_count", int'(alive_count), m_count);
        check("all_dead", int'(all_dead), int'(m_count == 0));
        check("reached_bottom", int'(reached_bottom), int'(model_bottom()));
    endtask

    function automatic int rnd_x();
        int px;
        px = int'($urandom_range(0, 299)) + m_topx - 20;
        return (px < 0) ? 0 : px;
    endfunction

    function automatic int rnd_y();
        int py;
        py = int'($urandom_range(0, 139)) + m_topy - 20;
        return (py < 0) ? 0 : py;
    endfunction

    // One frame strobe pulse (high one cycle, low one cycle)
    task automatic pulse(input bit en, input bit hv, input int hr, input int hc);
        apply(1, en, hv, hr, hc, rnd_x(), rnd_y());
        apply(0, en, 0, 0, 0, rnd_x(), rnd_y());
    endtask

    task automatic probe(input string name, input int px, input int py,
                         input bit e_draw, input int e_rgb);
        apply(0, 0, 0, 0, 0, px, py);
        check({name, "_draw"}, int'(draw_request), int'(e_draw));
        check({name, "_rgb"}, int'(RGBout), e_rgb);
    endtask

    typedef struct {
        bit hv; int hr; int hc; int px; int py;
        bit e_draw; int e_rgb; int e_count;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int guard;

        tbl[0]  = '{0, 0, 0,  64,  48, 1, 'h1C, 24};
        tbl[1]  = '{0, 0, 0,  88,  48, 0, 0,    24};
        tbl[2]  = '{0, 0, 0,  87,  48, 1, 'h1C, 24};
        tbl[3]  = '{0, 0, 0,  96,  48, 1, 'h1C, 24};
        tbl[4]  = '{0, 0, 0,  64,  64, 0, 0,    24};
        tbl[5]  = '{0, 0, 0,  64,  63, 1, 'h1C, 24};
        tbl[6]  = '{0, 0, 0,  63,  48, 0, 0,    24};
        tbl[7]  = '{0, 0, 0, 288,  48, 1, 'h1C, 24};
        tbl[8]  = '{0, 0, 0, 320,  48, 0, 0,    24};
        tbl[9]  = '{0, 0, 0,  64, 112, 1, 'h1C, 24};
        tbl[10] = '{0, 0, 0,  64, 144, 0, 0,    24};
        tbl[11] = '{1, 1, 2, 128,  80, 1, 'h1C, 23};
        tbl[12] = '{0, 0, 0, 128,  80, 0, 0,    23};
        tbl[13] = '{1, 1, 2, 128,  80, 0, 0,    23};
        tbl[14] = '{1, 5, 0,  64,  48, 1, 'h1C, 23};
        tbl[15] = '{1, 0, 8,  64,  48, 1, 'h1C, 23};

        resetN = 1'b0; startOfFrame = 0; enable = 0; hit_valid = 0;
        hit_row = '0; hit_col = '0; pixelX = '0; pixelY = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        check("rst_draw", int'(draw_request), 0);
        check("rst_rgb", int'(RGBout), 0);
        check("rst_count", int'(alive_count), 24);
        check("rst_all_dead", int'(all_dead), 0);
        check("rst_bottom", int'(reached_bottom), 0);
        resetN = 1'b1;

        // Directed table: draw geometry and hit filtering
        for (int i = 0; i < 16; i++) begin
            apply(0, 1, tbl[i].hv, tbl[i].hr, tbl[i].hc, tbl[i].px, tbl[i].py);
            check($sformatf("tbl%0d_draw", i), int'(draw_request), int'(tbl[i].e_draw));
            check($sformatf("tbl%0d_rgb", i), int'(RGBout), tbl[i].e_rgb);
            check($sformatf("tbl%0d_count", i), int'(alive_count), tbl[i].e_count);
        end

        // Seven ticks do not move, the eighth does and flips colour
        repeat (7) pulse(1, 0, 0, 0);
        probe("seven_pulses", 64, 48, 1, 'h1C);
        pulse(1, 0, 0, 0);
        probe("moved_old", 64, 48, 0, 0);
        probe("moved_new", 68, 48, 1, 'hFC);

        // March to the right edge, then drop and reverse
        guard = 0;
        while (m_topx < 384 && guard < 200) begin
            repeat (MOVE_PERIOD) pulse(1, 0, 0, 0);
            guard++;
        end
        probe("at_edge", 384, 48, 1, 'h1C);
        repeat (MOVE_PERIOD) pulse(1, 0, 0, 0);
        probe("dropped", 384, 64, 1, 'hFC);
        probe("dropped_above", 384, 63, 0, 0);
        repeat (MOVE_PERIOD) pulse(1, 0, 0, 0);
        probe("left_step", 380, 64, 1, 'h1C);

        // Hit on the same edge as a move
        repeat (MOVE_PERIOD - 1) pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        check("hit_move_count", int'(alive_count), 22);
        probe("hit_move_dead", 376, 64, 0, 0);
        probe("hit_move_next", 408, 64, 1, 'hFC);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 15) == 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), rnd_x(), rnd_y());
        end

        // Drive down to the bottom, then confirm the formation is frozen
        guard = 0;
        while (!model_bottom() && guard < 20000) begin
            pulse(1, 0, 0, 0);
            guard++;
        end
        if (!model_bottom()) begin
            miscompares++;
            $display("FAIL bottom_budget: got topY %0d expected >= %0d", m_topy, BOTTOM_Y - ROWS * CELL_H);
        end
        check("reached_bottom", int'(reached_bottom), 1);
        repeat (3 * MOVE_PERIOD) pulse(1, 0, 0, 0);
        check("frozen_bottom", int'(reached_bottom), 1);

        // Kill every alien; nothing may be drawn afterwards
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                apply(0, 1, 1, r, c, rnd_x(), rnd_y());
        check("all_dead", int'(all_dead), 1);
        check("all_dead_count", int'(alive_count), 0);
        for (int i = 0; i < 200; i++) begin
            apply(0, 1, 0, 0, 0, rnd_x(), rnd_y());
            check("dead_draw", int'(draw_request), 0);
        end

        // Asynchronous reset mid-cycle
        #2;
        resetN = 1'b0;
        #1;
        vectors++;
        check("arst_draw", int'(draw_request), 0);
        check("arst_rgb", int'(RGBout), 0);
        check("arst_count", int'(alive_count), 24);
        check("arst_all_dead", int'(all_dead), 0);
        check("arst_bottom", int'(reached_bottom), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        probe("post_rst", 64, 48, 1, 'h1C);
        probe("post_rst_left", 60, 48, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
